fann_io_host: RTL and testbench
===============================

FANN_IO_HOST -- requirements
Module: fann_io_host

Interface
REQ-001 SHALL have parameter WORD_W, default 11, the pad word width of the chip's input and output FIFO data.
REQ-002 SHALL have parameter LEN_W, default 16, the width of the command word count.
REQ-003 SHALL have parameter TIMEOUT, default 24'd1000000, the maximum RUN wait in cycles.
REQ-004 SHALL have one clock and synchronous active-high reset: wb_clk_i  in  1  clock, which also drives the chip's io_clk pad; wb_rst_i  in  1  reset.
REQ-005 Command port SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_op in 2 (0=LOAD, 1=RUN, 2=SEND, 3=reserved); cmd_len in LEN_W, the word count.
REQ-006 Source stream SHALL be: src_valid in 1; src_data in WORD_W; src_ready out 1.
REQ-007 Sink stream SHALL be: snk_valid out 1; snk_data out WORD_W; snk_ready in 1.
REQ-008 Chip input-FIFO side SHALL be: in_fifo_wenq out 1; in_fifo_wdata out WORD_W; in_fifo_wfull_n in 1.
REQ-009 Chip output-FIFO side SHALL be: out_fifo_deq out 1; out_fifo_rdata in WORD_W (valid while rempty_n); out_fifo_rempty_n in 1.
REQ-010 Chip control pins SHALL be: load_kdtree out 1; fsm_start out 1; send_best_arr out 1; fsm_done in 1; chip_wbs_busy in 1.
REQ-011 Status SHALL be: busy out 1; job_done out 1 (one-cycle pulse); err_timeout out 1 (sticky).

Function
REQ-012 FSM states SHALL be IDLE, LOAD, RUN, SEND, DONE.
REQ-013 cmd_ready SHALL equal (state==IDLE) & ~chip_wbs_busy.
REQ-014 A command SHALL be accepted when cmd_valid & cmd_ready; at that point cmd_len is latched into remaining count cnt.
REQ-015 On acceptance, the block SHALL go to LOAD/RUN/SEND per cmd_op; op 3 SHALL be accepted and go directly to DONE.
REQ-016 On the first cycle after entering LOAD/RUN/SEND, the block SHALL pulse load_kdtree/fsm_start/send_best_arr respectively, high for exactly 1 cycle, registered.
REQ-017 LOAD: in_fifo_wenq SHALL equal src_valid & in_fifo_wfull_n & (cnt!=0), combinational; in_fifo_wdata SHALL equal src_data; src_ready SHALL equal in_fifo_wfull_n & (cnt!=0).
REQ-018 LOAD: each handshake SHALL decrement cnt; cnt==0 SHALL move to DONE on the next edge.
REQ-019 LOAD with cmd_len=0 SHALL still emit the load_kdtree pulse, issue 0 writes, and then reach DONE.
REQ-020 Outside LOAD, in_fifo_wenq and src_ready SHALL be 0.
REQ-021 RUN: a 24-bit timer SHALL clear on entry and increment each cycle.
REQ-022 RUN: fsm_done high SHALL move to DONE.
REQ-023 RUN: timer==TIMEOUT-1 without fsm_done SHALL set err_timeout and move to DONE.
REQ-024 RUN: if fsm_done is high on the same cycle the timer expires, fsm_done SHALL win and err_timeout SHALL not be set.
REQ-025 RUN: fsm_done outside RUN SHALL be ignored.
REQ-026 SEND: a 2-entry receive FIFO rx SHALL be used, with registered data and a count of 0..2.
REQ-027 SEND: out_fifo_deq SHALL equal out_fifo_rempty_n & (rx not full) & (cnt!=0); on deq, out_fifo_rdata SHALL be written to rx and cnt SHALL decrement.
REQ-028 snk_valid SHALL equal rx not empty, and snk_data SHALL be the rx head, with no added latency beyond 1 cycle from deq.
REQ-029 A simultaneous rx push and pop SHALL keep the rx count unchanged and preserve word order.
REQ-030 SEND SHALL move to DONE when cnt==0 and rx is empty; cmd_len=0 SHALL move to DONE after the send_best_arr pulse.
REQ-031 Outside SEND, out_fifo_deq SHALL be 0.
REQ-032 DONE SHALL last exactly 1 cycle with job_done=1, then return to IDLE.
REQ-033 busy SHALL equal state!=IDLE.
REQ-034 err_timeout SHALL clear only on reset or on acceptance of a RUN command.
REQ-035 cnt SHALL never wrap below 0.

Reset
REQ-036 While wb_rst_i is high at a clock edge, the block SHALL go to IDLE with cnt=0, timer=0, rx emptied, and err_timeout=0.
REQ-037 During reset, all outputs SHALL be 0 except cmd_ready, which SHALL follow REQ-013 after reset release.
REQ-038 A reset asserted mid-LOAD or mid-SEND SHALL abort the job with no job_done pulse and drop rx contents.

Verification
REQ-039 LOAD len=4, src always valid, in_fifo_wfull_n toggling 1,0,1,1,0,1 -> exactly 4 wenq cycles, only when wfull_n=1, data in src order, then job_done 1 cycle.
REQ-040 RUN, fsm_done at cycle 10 -> fsm_start pulse 1 cycle, job_done 1 cycle after, err_timeout=0; RUN with TIMEOUT=16, no done -> err_timeout=1 after 16 cycles, then job_done.
REQ-041 SEND len=5, out_fifo_rempty_n=1, snk_ready low for 4 cycles then high -> at most 2 deq before stall, 5 words on sink in order, no loss.
REQ-042 cmd_valid while chip_wbs_busy=1 -> cmd_ready=0, no pulse; releasing chip_wbs_busy -> command accepted next cycle.
REQ-043 wb_rst_i mid-SEND with rx holding 2 words -> snk_valid=0, out_fifo_deq=0, state IDLE, no job_done.
REQ-044 LOAD len=0 and op=3 -> pulse behaviour as REQ-015/REQ-019, zero wenq, job_done within 3 cycles.

Source files
------------

// File: rtl/fann_io_host.sv
// Host sequencer: runs LOAD/RUN/SEND jobs against the chip FIFOs and control pins; pulses 1 cycle after entry.
// LOAD/SEND throttle on chip FIFO flags and the sink, with a 2-word receive buffer; RUN ends on fsm_done or timeout.
module fann_io_host #(
  parameter int          WORD_W  = 11,
  parameter int          LEN_W   = 16,
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic              wb_clk_i,       // also the chip io_clk
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              src_valid,
  input  logic [WORD_W-1:0] src_data,
  output logic              src_ready,
  output logic              snk_valid,
  output logic [WORD_W-1:0] snk_data,
  input  logic              snk_ready,
  output logic              in_fifo_wenq,
  output logic [WORD_W-1:0] in_fifo_wdata,
  input  logic              in_fifo_wfull_n,
  output logic              out_fifo_deq,
  input  logic [WORD_W-1:0] out_fifo_rdata,
  input  logic              out_fifo_rempty_n,
  output logic              load_kdtree,
  output logic              fsm_start,
  output logic              send_best_arr,
  input  logic              fsm_done,
  input  logic              chip_wbs_busy,
  output logic              busy,
  output logic              job_done,
  output logic              err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_SEND, S_DONE} state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [23:0]       timer_q;
  logic [WORD_W-1:0] rx_mem_q [0:1];
  logic              rx_wr_q, rx_rd_q;
  logic [1:0]        rx_cnt_q, rx_cnt_d;
  logic              load_q, start_q, send_q, job_done_q, err_q;

  logic cnt_nz, cmd_acc, rx_pop;

  assign cnt_nz  = (cnt_q != '0);
  // Combinational handshakes are forced low while reset is held.
  assign cmd_ready     = ~wb_rst_i & (state_q == S_IDLE) & ~chip_wbs_busy;
  assign cmd_acc       = cmd_valid & cmd_ready;
  assign src_ready     = ~wb_rst_i & (state_q == S_LOAD) & in_fifo_wfull_n & cnt_nz;
  assign in_fifo_wenq  = src_ready & src_valid;
  assign in_fifo_wdata = wb_rst_i ? '0 : src_data;
  assign out_fifo_deq  = ~wb_rst_i & (state_q == S_SEND) & out_fifo_rempty_n &
                         (rx_cnt_q != 2'd2) & cnt_nz;
  assign snk_valid     = ~wb_rst_i & (rx_cnt_q != 2'd0);
  assign snk_data      = snk_valid ? rx_mem_q[rx_rd_q] : '0;
  assign rx_pop        = snk_valid & snk_ready;
  assign rx_cnt_d      = rx_cnt_q + {1'b0, out_fifo_deq} - {1'b0, rx_pop};

  assign load_kdtree   = load_q;
  assign fsm_start     = start_q;
  assign send_best_arr = send_q;
  assign job_done      = job_done_q;
  assign err_timeout   = err_q;
  assign busy          = (state_q != S_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
      rx_wr_q    <= 1'b0;
      rx_rd_q    <= 1'b0;
      rx_cnt_q   <= 2'd0;
      load_q     <= 1'b0;
      start_q    <= 1'b0;
      send_q     <= 1'b0;
      job_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      load_q     <= 1'b0;
      start_q    <= 1'b0;
      send_q     <= 1'b0;
      job_done_q <= 1'b0;
      if (out_fifo_deq) begin
        rx_mem_q[rx_wr_q] <= out_fifo_rdata;
        rx_wr_q           <= ~rx_wr_q;
      end
      if (rx_pop) rx_rd_q <= ~rx_rd_q;
      rx_cnt_q <= rx_cnt_d;

      case (state_q)
        S_IDLE: begin
          if (cmd_acc) begin
            cnt_q   <= cmd_len;
            timer_q <= '0;
            case (cmd_op)
              2'd0: begin state_q <= S_LOAD; load_q <= 1'b1; end
              2'd1: begin state_q <= S_RUN; start_q <= 1'b1; err_q <= 1'b0; end
              2'd2: begin state_q <= S_SEND; send_q <= 1'b1; end
              default: begin state_q <= S_DONE; job_done_q <= 1'b1; end
            endcase
          end
        end
        S_LOAD: begin
          if (in_fifo_wenq) cnt_q <= cnt_q - LEN_W'(1);
          if (!cnt_nz) begin
            state_q    <= S_DONE;
            job_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          timer_q <= timer_q + 24'd1;
          // A done arriving on the expiry cycle wins over the timeout.
          if (fsm_done) begin
            state_q    <= S_DONE;
            job_done_q <= 1'b1;
          end else if (timer_q == TIMEOUT - 24'd1) begin
            err_q      <= 1'b1;
            state_q    <= S_DONE;
            job_done_q <= 1'b1;
          end
        end
        S_SEND: begin
          if (out_fifo_deq) cnt_q <= cnt_q - LEN_W'(1);
          if (!cnt_nz && rx_cnt_q == 2'd0) begin
            state_q    <= S_DONE;
            job_done_q <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fann_io_host.sv
// Randomised bench for fann_io_host: chip FIFO models plus a per-job expectation of words, pulses and timing.
module tb_fann_io_host;
  localparam int WORD_W = 11;
  localparam int LEN_W  = 16;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic              src_valid, src_ready;
  logic [WORD_W-1:0] src_data;
  logic              snk_valid, snk_ready;
  logic [WORD_W-1:0] snk_data;
  logic              in_fifo_wenq, in_fifo_wfull_n;
  logic [WORD_W-1:0] in_fifo_wdata;
  logic              out_fifo_deq, out_fifo_rempty_n;
  logic [WORD_W-1:0] out_fifo_rdata;
  logic              load_kdtree, fsm_start, send_best_arr, fsm_done, chip_wbs_busy;
  logic              busy, job_done, err_timeout;

  always #5 clk = ~clk;

  fann_io_host #(.WORD_W(WORD_W), .LEN_W(LEN_W), .TIMEOUT(24'(TMO))) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .in_fifo_wenq(in_fifo_wenq), .in_fifo_wdata(in_fifo_wdata), .in_fifo_wfull_n(in_fifo_wfull_n),
    .out_fifo_deq(out_fifo_deq), .out_fifo_rdata(out_fifo_rdata), .out_fifo_rempty_n(out_fifo_rempty_n),
    .load_kdtree(load_kdtree), .fsm_start(fsm_start), .send_best_arr(send_best_arr),
    .fsm_done(fsm_done), .chip_wbs_busy(chip_wbs_busy),
    .busy(busy), .job_done(job_done), .err_timeout(err_timeout)
  );

  int checks = 0, failures = 0;
  int n_load, n_start, n_send, n_done, n_deq, bad_wenq, max_out;
  int cyc = 0, start_cyc, done_cyc, acc_cyc;
  int src_idx, out_idx, out_len;
  logic err_at_done, acc, rempty_want, mode_rnd;
  logic lv_cmd_ready, lv_busy, lv_snk_valid, lv_deq;
  logic [10:0] lv_outs;
  logic [WORD_W-1:0] wq[$], sq[$];
  logic [WORD_W-1:0] src_words [64];
  logic [WORD_W-1:0] out_words [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_load = 0; n_start = 0; n_send = 0; n_done = 0; n_deq = 0;
    bad_wenq = 0; max_out = 0; src_idx = 0; out_idx = 0; out_len = 0;
    start_cyc = 0; done_cyc = 0; err_at_done = 1'b0;
    wq.delete(); sq.delete();
    for (int i = 0; i < 64; i++) begin
      src_words[i] = WORD_W'($urandom);
      out_words[i] = WORD_W'($urandom);
    end
  endtask

  // One clock: apply FIFO-model outputs, sample at negedge, advance models after the edge.
  task automatic tick();
    logic lw, ld;
    int outst;
    out_fifo_rempty_n = rempty_want && (out_idx < out_len);
    out_fifo_rdata    = out_words[out_idx % 64];
    src_data          = src_words[src_idx % 64];
    @(negedge clk);
    cyc++;
    acc          = cmd_valid & cmd_ready;
    lv_cmd_ready = cmd_ready;
    lv_busy      = busy;
    lv_snk_valid = snk_valid;
    lv_deq       = out_fifo_deq;
    lv_outs      = {busy, job_done, err_timeout, snk_valid, out_fifo_deq, in_fifo_wenq,
                    src_ready, load_kdtree, fsm_start, send_best_arr, cmd_ready};
    if (in_fifo_wenq) begin
      wq.push_back(in_fifo_wdata);
      if (!in_fifo_wfull_n) bad_wenq++;
    end
    if (load_kdtree) n_load++;
    if (fsm_start) begin n_start++; start_cyc = cyc; end
    if (send_best_arr) n_send++;
    if (job_done) begin n_done++; done_cyc = cyc; err_at_done = err_timeout; end
    if (snk_valid && snk_ready) sq.push_back(snk_data);
    if (out_fifo_deq) n_deq++;
    outst = n_deq - sq.size();
    if (outst > max_out) max_out = outst;
    lw = in_fifo_wenq;
    ld = out_fifo_deq;
    @(posedge clk);
    #1;
    if (lw) src_idx++;
    if (ld) out_idx++;
  endtask

  task automatic rnd_inputs();
    if (mode_rnd) begin
      src_valid       = 1'($urandom);
      in_fifo_wfull_n = 1'($urandom);
      snk_ready       = 1'($urandom);
      rempty_want     = 1'($urandom);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int len);
    cmd_op = op; cmd_len = LEN_W'(len); cmd_valid = 1'b1; acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc), 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) begin
      rnd_inputs();
      tick();
    end
    check("job_done_cnt", n_done, 1);
  endtask

  task automatic run_job(input int k);
    clear_stats();
    issue(2'd1, 0);
    for (int i = 1; i <= 40 && n_done == 0; i++) begin
      fsm_done = (i == k);
      tick();
    end
    fsm_done = 1'b0;
    check("run_start", n_start, 1);
    check("run_done", n_done, 1);
    check("run_latency", done_cyc - start_cyc, (k == 0) ? TMO : k);
    check("run_err", 32'(err_at_done), (k == 0) ? 1 : 0);
  endtask

  task automatic load_job(input int len);
    clear_stats();
    issue(2'd0, len);
    wait_done(200);
    check("load_pulse", n_load, 1);
    check("load_words", wq.size(), len);
    check("load_wfull", bad_wenq, 0);
    if (wq.size() == len)
      for (int i = 0; i < len; i++) check("load_data", wq[i], src_words[i]);
  endtask

  task automatic send_job(input int len);
    clear_stats();
    out_len = len;
    issue(2'd2, len);
    wait_done(200);
    check("send_pulse", n_send, 1);
    check("send_deq", n_deq, len);
    check("send_words", sq.size(), len);
    check("send_rxmax", 32'(max_out <= 2), 1);
    if (sq.size() == len)
      for (int i = 0; i < len; i++) check("send_data", sq[i], out_words[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pat [6];
    int k;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = '0;
    src_valid = 1'b0; in_fifo_wfull_n = 1'b1; snk_ready = 1'b0;
    rempty_want = 1'b0; fsm_done = 1'b0; chip_wbs_busy = 1'b0; mode_rnd = 1'b0;
    clear_stats();
    repeat (3) tick();
    check("rst_outputs", 32'(lv_outs), 0);
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", 32'(lv_cmd_ready), 1);
    check("rst_busy", 32'(lv_busy), 0);

    // Fixed wfull_n pattern: writes only on the 1-cycles, in source order.
    clear_stats();
    src_valid = 1'b1;
    issue(2'd0, 4);
    for (int i = 0; i < 30 && n_done == 0; i++) begin
      in_fifo_wfull_n = (i < 6) ? pat[i] : 1'b1;
      tick();
    end
    check("ldp_words", wq.size(), 4);
    check("ldp_wfull", bad_wenq, 0);
    check("ldp_done", n_done, 1);
    if (wq.size() == 4) for (int i = 0; i < 4; i++) check("ldp_data", wq[i], src_words[i]);

    mode_rnd = 1'b1;
    repeat (4) load_job($urandom_range(1, 8));
    mode_rnd = 1'b0;

    // Zero-length LOAD and reserved op.
    load_job(0);
    check("ld0_latency", 32'(done_cyc - acc_cyc <= 3), 1);
    clear_stats();
    issue(2'd3, 5);
    wait_done(10);
    check("op3_pulses", n_load + n_start + n_send, 0);
    check("op3_latency", 32'(done_cyc - acc_cyc <= 3), 1);
    check("op3_wenq", wq.size(), 0);

    run_job(10);
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, TMO - 1);
      run_job(k);
    end
    run_job(0);
    tick();
    check("err_sticky", 32'(err_timeout), 1);
    clear_stats();
    fsm_done = 1'b1;
    repeat (3) tick();
    fsm_done = 1'b0;
    check("idle_fsm_done_busy", 32'(lv_busy), 0);
    check("idle_fsm_done_job", n_done, 0);
    run_job(TMO);

    // SEND with a stalled sink: rx fills to 2 then drains in order.
    clear_stats();
    out_len = 5; rempty_want = 1'b1; snk_ready = 1'b0;
    issue(2'd2, 5);
    repeat (4) tick();
    check("snd_stall_deq", n_deq, 2);
    check("snd_stall_sink", sq.size(), 0);
    snk_ready = 1'b1;
    wait_done(100);
    check("snd_words", sq.size(), 5);
    if (sq.size() == 5) for (int i = 0; i < 5; i++) check("snd_data", sq[i], out_words[i]);
    check("snd_rxmax", max_out, 2);

    mode_rnd = 1'b1;
    repeat (3) send_job($urandom_range(1, 8));
    mode_rnd = 1'b0;
    send_job(0);

    // Chip busy holds off command acceptance.
    clear_stats();
    chip_wbs_busy = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = '0;
    repeat (4) tick();
    check("wbs_busy_ready", 32'(lv_cmd_ready), 0);
    check("wbs_busy_pulse", n_load, 0);
    chip_wbs_busy = 1'b0;
    tick();
    check("wbs_rel_acc", 32'(acc), 1);
    cmd_valid = 1'b0;
    tick();
    check("wbs_rel_pulse", n_load, 1);
    wait_done(10);

    // Reset while rx holds two words.
    clear_stats();
    out_len = 6; rempty_want = 1'b1; snk_ready = 1'b0;
    issue(2'd2, 6);
    repeat (4) tick();
    check("rstsnd_deq", n_deq, 2);
    rst = 1'b1;
    tick();
    check("rstsnd_snk_valid", 32'(lv_snk_valid), 0);
    check("rstsnd_deq_low", 32'(lv_deq), 0);
    tick();
    rst = 1'b0;
    rempty_want = 1'b0;
    tick();
    check("rstsnd_idle", 32'(lv_busy), 0);
    check("rstsnd_rx_empty", 32'(lv_snk_valid), 0);
    check("rstsnd_no_done", n_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
